// File: rtl/skewed_tag_store_if.sv
// Request/response bundle for the skewed tag store.
// Latency: none, wires only.
// Backpressure: insert_ready_o gates inserts; lookups are never back-pressured.
interface skewed_tag_store_if #(
  parameter int WIDTH       = 64,
  parameter int TAG_WIDTH   = 12,
  parameter int INDEX_WIDTH = 6,
  parameter int BW          = 1
);
  logic                   lookup_valid_i;
  logic [WIDTH-1:0]       lookup_addr_i;
  logic                   lookup_valid_o;
  logic                   lookup_hit_o;
  logic [BW-1:0]          lookup_bank_o;
  logic                   insert_valid_i;
  logic [WIDTH-1:0]       insert_addr_i;
  logic                   insert_ready_o;
  logic                   evict_valid_o;
  logic [TAG_WIDTH-1:0]   evict_tag_o;
  logic [BW-1:0]          evict_bank_o;
  logic [INDEX_WIDTH-1:0] evict_index_o;
  logic                   flush_i;
  logic                   busy_o;

  // Requester side: drives lookups, inserts and flushes.
  modport master (
    output lookup_valid_i, lookup_addr_i, insert_valid_i, insert_addr_i, flush_i,
    input  lookup_valid_o, lookup_hit_o, lookup_bank_o, insert_ready_o,
    input  evict_valid_o, evict_tag_o, evict_bank_o, evict_index_o, busy_o
  );

  // Store side.
  modport slave (
    input  lookup_valid_i, lookup_addr_i, insert_valid_i, insert_addr_i, flush_i,
    output lookup_valid_o, lookup_hit_o, lookup_bank_o, insert_ready_o,
    output evict_valid_o, evict_tag_o, evict_bank_o, evict_index_o, busy_o
  );
endinterface

// File: rtl/skewed_tag_store.sv
// Skewed-associative tag store: each bank hashes the address with its own XOR skew.
// Latency: lookup result and eviction report one cycle after the request edge.
// Backpressure: insert_ready_o drops while a flush sweep runs or is being requested.
module skewed_tag_store #(
  parameter  int WIDTH       = 64,
  parameter  int TAG_WIDTH   = 12,
  parameter  int INDEX_WIDTH = 6,
  parameter  int NUM_BANKS   = 2,
  localparam int BW          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int SIZE        = 1 << INDEX_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  skewed_tag_store_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [INDEX_WIDTH:0] SWEEP_ONE  = (INDEX_WIDTH+1)'(1);
  localparam logic [INDEX_WIDTH:0] SWEEP_LAST = (INDEX_WIDTH+1)'(SIZE - 1);
  localparam logic [BW-1:0]        RR_ONE     = BW'(1);
  localparam logic [BW-1:0]        RR_LAST    = BW'(NUM_BANKS - 1);

  state_t state_q, state_d;
  // One bit wider than the index so the final sweep value never aliases 0.
  logic [INDEX_WIDTH:0]   sweep_q;
  logic [BW-1:0]          rr_q;
  logic [TAG_WIDTH-1:0]   tag_mem [NUM_BANKS][SIZE];
  logic [SIZE-1:0]        vld_q   [NUM_BANKS];

  logic [TAG_WIDTH-1:0]   lk_tag;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic [INDEX_WIDTH-1:0] lk_idx  [NUM_BANKS];
  logic [INDEX_WIDTH-1:0] in_idx  [NUM_BANKS];
  logic                   lk_hit;
  logic [BW-1:0]          lk_bank;
  logic                   in_present;
  logic                   in_has_free;
  logic [BW-1:0]          in_free_bank;
  logic                   ins_fire;
  logic                   wr_en;
  logic                   evict;
  logic [BW-1:0]          wr_bank;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic [TAG_WIDTH-1:0]   victim_tag;
  logic                   lk_report;

  // Bank b skews the low index bits with the address shifted by INDEX_WIDTH*2^b.
  function automatic logic [INDEX_WIDTH-1:0] bank_index(input logic [WIDTH-1:0] addr,
                                                        input int b);
    logic [WIDTH-1:0] sh;
    sh = addr >> (INDEX_WIDTH << b);
    return addr[INDEX_WIDTH-1:0] ^ sh[INDEX_WIDTH-1:0];
  endfunction

  assign lk_tag = bus.lookup_addr_i[INDEX_WIDTH +: TAG_WIDTH];
  assign in_tag = bus.insert_addr_i[INDEX_WIDTH +: TAG_WIDTH];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_idx
    assign lk_idx[g] = bank_index(bus.lookup_addr_i, g);
    assign in_idx[g] = bank_index(bus.insert_addr_i, g);
  end

  // Lookup match: scan high to low so the lowest matching bank wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (vld_q[b][lk_idx[b]] && (tag_mem[b][lk_idx[b]] == lk_tag)) begin
        lk_hit  = 1'b1;
        lk_bank = BW'(b);
      end
    end
  end

  // Insert placement: detect an existing copy and find the lowest free bank.
  always_comb begin
    in_present   = 1'b0;
    in_has_free  = 1'b0;
    in_free_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (vld_q[b][in_idx[b]] && (tag_mem[b][in_idx[b]] == in_tag)) begin
        in_present = 1'b1;
      end
      if (!vld_q[b][in_idx[b]]) begin
        in_has_free  = 1'b1;
        in_free_bank = BW'(b);
      end
    end
  end

  assign bus.insert_ready_o = (state_q == IDLE) && !bus.flush_i;
  assign bus.busy_o         = (state_q == FLUSH);

  assign ins_fire   = bus.insert_valid_i && bus.insert_ready_o;
  assign wr_en      = ins_fire && !in_present;
  assign evict      = wr_en && !in_has_free;
  assign wr_bank    = in_has_free ? in_free_bank : rr_q;
  assign wr_idx     = in_idx[wr_bank];
  assign victim_tag = tag_mem[rr_q][in_idx[rr_q]];
  // Nothing can hit while the sweep is tearing the arrays down.
  assign lk_report  = bus.lookup_valid_i && (state_q == IDLE) && lk_hit;

  // Flush FSM next state: a sweep runs to its last index and cannot be re-triggered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush_i) state_d = FLUSH;
      FLUSH:   if (sweep_q == SWEEP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH) begin
        sweep_q <= (state_d == IDLE) ? '0 : sweep_q + SWEEP_ONE;
      end
    end
  end

  // Valid bits: reset clears all, sweep clears one index per cycle, insert sets one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) vld_q[b] <= '0;
    end else if (state_q == FLUSH) begin
      for (int b = 0; b < NUM_BANKS; b++) vld_q[b][sweep_q[INDEX_WIDTH-1:0]] <= 1'b0;
    end else if (wr_en) begin
      vld_q[wr_bank][wr_idx] <= 1'b1;
    end
  end

  // Tag array write; tags are meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_bank][wr_idx] <= in_tag;
  end

  // Registered lookup result, eviction report and round-robin victim pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.lookup_valid_o <= 1'b0;
      bus.lookup_hit_o   <= 1'b0;
      bus.lookup_bank_o  <= '0;
      bus.evict_valid_o  <= 1'b0;
      bus.evict_tag_o    <= '0;
      bus.evict_bank_o   <= '0;
      bus.evict_index_o  <= '0;
      rr_q               <= '0;
    end else begin
      bus.lookup_valid_o <= bus.lookup_valid_i;
      bus.lookup_hit_o   <= lk_report;
      bus.lookup_bank_o  <= lk_report ? lk_bank : '0;
      bus.evict_valid_o  <= evict;
      if (evict) begin
        bus.evict_tag_o   <= victim_tag;
        bus.evict_bank_o  <= rr_q;
        bus.evict_index_o <= in_idx[rr_q];
        rr_q              <= (rr_q == RR_LAST) ? '0 : rr_q + RR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_skewed_tag_store.sv
// Scoreboard bench for skewed_tag_store: a behavioural model predicts each cycle's outputs.
// Latency: expectations are queued before each edge and compared 1 ns after it.
// Backpressure: insert_ready_o is predicted and checked before every edge.
module tb_skewed_tag_store;
  localparam int WIDTH = 64, TAG_WIDTH = 12, INDEX_WIDTH = 6, NUM_BANKS = 2, BW = 1;
  localparam int SIZE = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  skewed_tag_store_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .BW(BW)) bus ();

  skewed_tag_store #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .INDEX_WIDTH(INDEX_WIDTH),
                     .NUM_BANKS(NUM_BANKS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic                   lv;
    logic                   hit;
    logic [BW-1:0]          bank;
    logic                   ev;
    logic                   fields;
    logic [TAG_WIDTH-1:0]   etag;
    logic [BW-1:0]          ebank;
    logic [INDEX_WIDTH-1:0] eidx;
    logic                   busy;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  bit                   m_vld [NUM_BANKS][SIZE];
  logic [TAG_WIDTH-1:0] m_tag [NUM_BANKS][SIZE];
  int                   m_rr;
  bit                   m_flush;
  int                   m_sweep;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INDEX_WIDTH-1:0] m_idx(input logic [WIDTH-1:0] a, input int b);
    logic [WIDTH-1:0] s;
    s = a >> (INDEX_WIDTH * (2 ** b));
    return a[INDEX_WIDTH-1:0] ^ s[INDEX_WIDTH-1:0];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] m_tagof(input logic [WIDTH-1:0] a);
    return a[INDEX_WIDTH +: TAG_WIDTH];
  endfunction

  // Predict this edge from the model, advance the model, then compare after the edge.
  task automatic step();
    exp_t e, got;
    bit found, present, freef;
    int fb;
    logic [INDEX_WIDTH-1:0] ix;
    logic [WIDTH-1:0] la, ia;
    #1;
    check_eq("insert_ready", bus.insert_ready_o, !m_flush && !bus.flush_i);
    e = '{default: '0};
    la = bus.lookup_addr_i;
    ia = bus.insert_addr_i;
    if (!rst_n) begin
      foreach (m_vld[b, i]) m_vld[b][i] = 0;
      m_rr = 0; m_flush = 0; m_sweep = 0;
      e.fields = 1'b1;
    end else begin
      e.lv = bus.lookup_valid_i;
      if (bus.lookup_valid_i && !m_flush) begin
        found = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
          ix = m_idx(la, b);
          if (!found && m_vld[b][ix] && m_tag[b][ix] == m_tagof(la)) begin
            found = 1; e.hit = 1'b1; e.bank = BW'(b);
          end
        end
      end
      if (m_flush) begin
        for (int b = 0; b < NUM_BANKS; b++) m_vld[b][m_sweep] = 0;
        if (m_sweep == SIZE - 1) begin m_flush = 0; m_sweep = 0; end
        else m_sweep++;
      end else if (bus.flush_i) begin
        m_flush = 1;
      end else if (bus.insert_valid_i) begin
        present = 0; freef = 0; fb = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
          ix = m_idx(ia, b);
          if (m_vld[b][ix] && m_tag[b][ix] == m_tagof(ia)) present = 1;
          if (!freef && !m_vld[b][ix]) begin freef = 1; fb = b; end
        end
        if (!present) begin
          if (!freef) begin
            fb = m_rr;
            ix = m_idx(ia, fb);
            e.ev = 1'b1; e.fields = 1'b1;
            e.etag = m_tag[fb][ix]; e.ebank = BW'(fb); e.eidx = ix;
            m_rr = (m_rr + 1) % NUM_BANKS;
          end
          ix = m_idx(ia, fb);
          m_vld[fb][ix] = 1;
          m_tag[fb][ix] = m_tagof(ia);
        end
      end
    end
    e.busy = m_flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("lookup_valid", bus.lookup_valid_o, got.lv);
    check_eq("lookup_hit", bus.lookup_hit_o, got.hit);
    check_eq("lookup_bank", bus.lookup_bank_o, got.bank);
    check_eq("evict_valid", bus.evict_valid_o, got.ev);
    check_eq("busy", bus.busy_o, got.busy);
    if (got.fields) begin
      check_eq("evict_tag", bus.evict_tag_o, got.etag);
      check_eq("evict_bank", bus.evict_bank_o, got.ebank);
      check_eq("evict_index", bus.evict_index_o, got.eidx);
    end
  endtask

  task automatic cyc(input logic lv, input logic [63:0] la, input logic iv,
                     input logic [63:0] ia, input logic fl);
    bus.lookup_valid_i = lv;
    bus.lookup_addr_i  = la;
    bus.insert_valid_i = iv;
    bus.insert_addr_i  = ia;
    bus.flush_i        = fl;
    step();
  endtask

  // Watchdog: a hang is reported and stops the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pool [8];
    int cnt;
    pool = '{64'h1040, 64'h2080, 64'h1041, 64'h2082, 64'h30C3, 64'h5145, 64'h6186, 64'h71C7};
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_reset", bus.insert_ready_o, 1);

    // Insert then look up next cycle: hit in bank 0.
    cyc(0, 0, 1, 64'h1040, 0);
    cyc(1, 64'h1040, 0, 0, 0);
    check_eq("basic_hit", bus.lookup_hit_o, 1);
    check_eq("basic_bank", bus.lookup_bank_o, 0);

    // Same-cycle insert and lookup reads the old state.
    cyc(1, 64'h2080, 1, 64'h2080, 0);
    check_eq("rbw_miss", bus.lookup_hit_o, 0);
    cyc(1, 64'h2080, 0, 0, 0);
    check_eq("rbw_hit", bus.lookup_hit_o, 1);

    // Set 0 in both banks: fill, evict bank 0, reinsert present, evict bank 1.
    cyc(0, 0, 1, 64'h1041, 0);
    cyc(0, 0, 1, 64'h2082, 0);
    cyc(0, 0, 1, 64'h30C3, 0);
    check_eq("evict1_valid", bus.evict_valid_o, 1);
    check_eq("evict1_bank", bus.evict_bank_o, 0);
    check_eq("evict1_tag", bus.evict_tag_o, 64'h041);
    cyc(0, 0, 0, 0, 0);
    check_eq("evict_pulse_end", bus.evict_valid_o, 0);
    cyc(0, 0, 1, 64'h30C3, 0);
    check_eq("reinsert_no_evict", bus.evict_valid_o, 0);
    cyc(0, 0, 1, 64'h5145, 0);
    check_eq("evict2_valid", bus.evict_valid_o, 1);
    check_eq("evict2_bank", bus.evict_bank_o, 1);
    check_eq("evict2_tag", bus.evict_tag_o, 64'h082);
    foreach (pool[i]) cyc(1, pool[i], 0, 0, 0);

    // Flush beats a same-cycle insert; count busy cycles.
    cyc(0, 0, 1, 64'h7000, 1);
    cnt = bus.busy_o ? 1 : 0;
    for (int k = 0; k < 150 && bus.busy_o; k++) begin
      cyc(1, 64'h5145, 1, 64'h7000, k[0]);
      if (bus.busy_o) cnt++;
    end
    check_eq("flush_busy_cycles", cnt, 64);
    foreach (pool[i]) cyc(1, pool[i], 0, 0, 0);
    cyc(1, 64'h7000, 0, 0, 0);
    check_eq("flush_blocked_insert", bus.lookup_hit_o, 0);

    // Reset in the middle of a sweep.
    cyc(0, 0, 1, 64'h1040, 0);
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check_eq("midflush_rst_busy", bus.busy_o, 0);
    check_eq("midflush_rst_ready", bus.insert_ready_o, 1);
    cyc(1, 64'h1040, 0, 0, 0);
    check_eq("midflush_rst_miss", bus.lookup_hit_o, 0);

    // Random traffic over a conflicting address pool.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom_range(0, 1),
          pool[$urandom_range(0, 7)], ($urandom_range(0, 79) == 0));
    end

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
